// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: field widths, instruction class
// and function encodings, ALU function codes and the FSM state type.
package definitions;

    localparam int INSTR_WIDTH    = 16;
    localparam int REG_ADDR_WIDTH = 3;
    localparam int FUNC_WIDTH     = 4;

    localparam logic [1:0] CLASS_ALU    = 2'b00;
    localparam logic [1:0] CLASS_LOAD   = 2'b01;
    localparam logic [1:0] CLASS_STORE  = 2'b10;
    localparam logic [1:0] CLASS_BRANCH = 2'b11;

    localparam logic [3:0] BR_LSS    = 4'h0;
    localparam logic [3:0] BR_EQL    = 4'h1;
    localparam logic [3:0] BR_GRT    = 4'h2;
    localparam logic [3:0] HALT_FUNC = 4'hF;

    // FUNC_SET is the idle code and must stay zero so reset drives funcCode low
    localparam logic [FUNC_WIDTH-1:0] FUNC_SET = 4'h0;
    localparam logic [FUNC_WIDTH-1:0] FUNC_ADD = 4'h1;
    localparam logic [FUNC_WIDTH-1:0] FUNC_SUB = 4'h2;
    localparam logic [FUNC_WIDTH-1:0] FUNC_AND = 4'h3;
    localparam logic [FUNC_WIDTH-1:0] FUNC_OR  = 4'h4;
    localparam logic [FUNC_WIDTH-1:0] FUNC_XOR = 4'h5;
    localparam logic [FUNC_WIDTH-1:0] FUNC_LSS = 4'hA;
    localparam logic [FUNC_WIDTH-1:0] FUNC_EQL = 4'hB;
    localparam logic [FUNC_WIDTH-1:0] FUNC_GRT = 4'hC;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6
    } cuState_t;

    typedef struct packed {
        logic [3:0]                func;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] ra;
        logic [REG_ADDR_WIDTH-1:0] rb;
        logic                      isAlu;
        logic                      isLoad;
        logic                      isStore;
        logic                      isBranch;
        logic                      isHalt;
        logic                      isBranchCmp;
    } decodedInstr_t;

    function automatic logic [FUNC_WIDTH-1:0] branchFuncCode(input logic [3:0] func);
        case (func)
            BR_LSS:  return FUNC_LSS;
            BR_EQL:  return FUNC_EQL;
            BR_GRT:  return FUNC_GRT;
            default: return FUNC_SET;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_instruction_decoder.sv
// Purely combinational split of an instruction word into register fields,
// function field and class flags.
module instruction_decoder
    import definitions::*;
(
    input  logic [INSTR_WIDTH-1:0] instr,
    output decodedInstr_t          fields
);

    logic [1:0] instrClass;
    logic       unusedBit;

    assign instrClass = instr[15:14];
    assign unusedBit  = instr[0];

    assign fields.func     = instr[13:10];
    assign fields.rd       = instr[9:7];
    assign fields.ra       = instr[6:4];
    assign fields.rb       = instr[3:1];
    assign fields.isAlu    = (instrClass == CLASS_ALU);
    assign fields.isLoad   = (instrClass == CLASS_LOAD);
    assign fields.isStore  = (instrClass == CLASS_STORE);
    assign fields.isBranch = (instrClass == CLASS_BRANCH) && (instr[13:10] != HALT_FUNC);
    assign fields.isHalt   = (instrClass == CLASS_BRANCH) && (instr[13:10] == HALT_FUNC);

    // Only the three comparison branches can ever be taken; others act as NOPs
    assign fields.isBranchCmp = (instrClass == CLASS_BRANCH) &&
                                ((instr[13:10] == BR_LSS) ||
                                 (instr[13:10] == BR_EQL) ||
                                 (instr[13:10] == BR_GRT));

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetches an instruction, decodes it and sequences
// the ALU, data memory, register file and PC strobes through a seven-state FSM.
module control_unit
    import definitions::*;
(
    input  logic                      _clock,
    input  logic                      _resetN,
    input  logic                      _start,
    input  logic [INSTR_WIDTH-1:0]    _instr,
    input  logic                      _instrValid,
    input  logic                      _memReady,
    input  logic                      _compareBit,
    input  logic                      _overflow,
    output logic                      instrReq,
    output logic [FUNC_WIDTH-1:0]     funcCode,
    output logic [REG_ADDR_WIDTH-1:0] rdAddr,
    output logic [REG_ADDR_WIDTH-1:0] raAddr,
    output logic [REG_ADDR_WIDTH-1:0] rbAddr,
    output logic                      regWrite,
    output logic                      memRead,
    output logic                      memWrite,
    output logic                      pcIncrement,
    output logic                      pcLoad,
    output logic                      overflowFlag,
    output logic                      halted
);

    cuState_t               state;
    cuState_t               nextState;
    logic [INSTR_WIDTH-1:0] instrReg;
    logic                   branchTaken;
    decodedInstr_t          dec;

    instruction_decoder decoder (
        .instr  (instrReg),
        .fields (dec)
    );

    always_ff @(posedge _clock or negedge _resetN) begin
        if (!_resetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ALU flags are captured on the edge that closes EXECUTE so WRITEBACK sees them
    always_ff @(posedge _clock or negedge _resetN) begin
        if (!_resetN) begin
            instrReg     <= '0;
            branchTaken  <= 1'b0;
            overflowFlag <= 1'b0;
        end else begin
            if (state == FETCH && _instrValid) begin
                instrReg <= _instr;
            end
            if (state == EXECUTE) begin
                branchTaken <= dec.isBranchCmp && _compareBit;
                if (dec.isAlu && _overflow) begin
                    overflowFlag <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        nextState   = state;
        instrReq    = 1'b0;
        funcCode    = FUNC_SET;
        regWrite    = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        pcIncrement = 1'b0;
        pcLoad      = 1'b0;
        halted      = 1'b0;
        rdAddr      = '0;
        raAddr      = '0;
        rbAddr      = '0;

        if (state inside {DECODE, EXECUTE, MEMORY, WRITEBACK, HALT}) begin
            rdAddr = dec.rd;
            raAddr = dec.ra;
            rbAddr = dec.rb;
        end

        case (state)
            IDLE: begin
                if (_start) begin
                    nextState = FETCH;
                end
            end
            FETCH: begin
                instrReq = 1'b1;
                if (_instrValid) begin
                    nextState = DECODE;
                end
            end
            DECODE: begin
                nextState = dec.isHalt ? HALT : EXECUTE;
            end
            EXECUTE: begin
                if (dec.isAlu) begin
                    funcCode = dec.func;
                end else if (dec.isBranch) begin
                    funcCode = branchFuncCode(dec.func);
                end
                nextState = (dec.isLoad || dec.isStore) ? MEMORY : WRITEBACK;
            end
            MEMORY: begin
                memRead  = dec.isLoad;
                memWrite = dec.isStore;
                if (_memReady) begin
                    nextState = WRITEBACK;
                end
            end
            WRITEBACK: begin
                regWrite = dec.isAlu || dec.isLoad;
                if (branchTaken) begin
                    pcLoad = 1'b1;
                end else begin
                    pcIncrement = 1'b1;
                end
                nextState = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random
// instructions compared against an instruction-level timing/strobe model.
module tb_control_unit;
    import definitions::*;

    logic        _clock = 1'b0;
    logic        _resetN;
    logic        _start;
    logic [15:0] _instr;
    logic        _instrValid;
    logic        _memReady;
    logic        _compareBit;
    logic        _overflow;
    logic        instrReq;
    logic [3:0]  funcCode;
    logic [2:0]  rdAddr;
    logic [2:0]  raAddr;
    logic [2:0]  rbAddr;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        pcIncrement;
    logic        pcLoad;
    logic        overflowFlag;
    logic        halted;

    int   checks = 0;
    int   errors = 0;
    logic ovfModel = 1'b0;
    logic [3:0] branchMap [16];

    control_unit dut (
        ._clock       (_clock),
        ._resetN      (_resetN),
        ._start       (_start),
        ._instr       (_instr),
        ._instrValid  (_instrValid),
        ._memReady    (_memReady),
        ._compareBit  (_compareBit),
        ._overflow    (_overflow),
        .instrReq     (instrReq),
        .funcCode     (funcCode),
        .rdAddr       (rdAddr),
        .raAddr       (raAddr),
        .rbAddr       (rbAddr),
        .regWrite     (regWrite),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .pcIncrement  (pcIncrement),
        .pcLoad       (pcLoad),
        .overflowFlag (overflowFlag),
        .halted       (halted)
    );

    always #5 _clock = ~_clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        _resetN     = 1'b0;
        _start      = 1'b0;
        _instrValid = 1'b0;
        _memReady   = 1'b0;
        @(negedge _clock);
        ovfModel = 1'b0;
        checkOutput("resetOutputs", 32'({instrReq, regWrite, memRead, memWrite, pcIncrement, pcLoad,
                                         halted, overflowFlag, funcCode, rdAddr, raAddr, rbAddr}), 32'd0);
        _resetN = 1'b1;
        repeat (3) @(negedge _clock);
        checkOutput("idleHold", 32'(instrReq), 32'd0);
    endtask

    task automatic startUnit();
        _start = 1'b1;
        @(negedge _clock);
        _start = 1'b0;
        checkOutput("startFetch", 32'(instrReq), 32'd1);
    endtask

    // Runs one instruction from a FETCH negedge to the next FETCH (or HALT) negedge
    task automatic applyStimulus(input logic [15:0] instr, input logic cmp, input logic ovf, input int memWait);
        logic [1:0] cls;
        logic [3:0] func;
        logic       isHalt, isMem, taken;
        int         expLat, expReg, expRd, expWr, expPcL, expPcI;
        logic [3:0] expFunc;
        int         k, memCnt, latency, nReg, nRd, nWr, nPcL, nPcI, nBoth;
        logic [3:0] funcSeen;
        logic [8:0] addrSeen;
        bit         done;

        cls     = instr[15:14];
        func    = instr[13:10];
        isHalt  = (cls == 2'b11) && (func == 4'hF);
        isMem   = (cls == 2'b01) || (cls == 2'b10);
        taken   = (cls == 2'b11) && (func < 4'd3) && cmp;
        expLat  = isHalt ? 2 : (isMem ? 5 + memWait : 4);
        expFunc = (cls == 2'b00) ? func : ((cls == 2'b11) ? branchMap[func] : FUNC_SET);
        expReg  = (!isHalt && cls < 2'd2) ? 1 : 0;
        expRd   = (cls == 2'b01) ? memWait + 1 : 0;
        expWr   = (cls == 2'b10) ? memWait + 1 : 0;
        expPcL  = taken ? 1 : 0;
        expPcI  = (!isHalt && !taken) ? 1 : 0;
        ovfModel = ovfModel | ((cls == 2'b00) && ovf);

        _instr = instr; _instrValid = 1'b1; _compareBit = cmp; _overflow = ovf; _memReady = 1'b0;
        done = 0; k = 0; memCnt = 0; latency = 0;
        nReg = 0; nRd = 0; nWr = 0; nPcL = 0; nPcI = 0; nBoth = 0;
        funcSeen = 4'h0; addrSeen = 9'h0;
        while (!done && k < 40) begin
            @(negedge _clock);
            k++;
            if (k == 1) addrSeen = {rdAddr, raAddr, rbAddr};
            if (k == 2) funcSeen = funcCode;
            if (instrReq || halted) begin
                done = 1; latency = k;
                _instrValid = 1'b0; _start = 1'b0; _memReady = 1'b0;
            end else begin
                if (regWrite) nReg++;
                if (memRead) nRd++;
                if (memWrite) nWr++;
                if (pcLoad) nPcL++;
                if (pcIncrement) nPcI++;
                if (pcLoad && pcIncrement) nBoth++;
                _instr      = 16'($urandom);
                _instrValid = 1'($urandom_range(0, 1));
                _start      = 1'($urandom_range(0, 1));
                if (memRead || memWrite) begin
                    _memReady = (memCnt == memWait);
                    memCnt++;
                end else begin
                    _memReady = 1'($urandom_range(0, 1));
                end
            end
        end
        checkOutput("finished", 32'(done), 32'd1);
        checkOutput("latency", 32'(latency), 32'(expLat));
        checkOutput("decodeAddr", 32'(addrSeen), 32'(instr[9:1]));
        checkOutput("execFunc", 32'(funcSeen), 32'(expFunc));
        checkOutput("regWriteCount", 32'(nReg), 32'(expReg));
        checkOutput("memReadCount", 32'(nRd), 32'(expRd));
        checkOutput("memWriteCount", 32'(nWr), 32'(expWr));
        checkOutput("pcLoadCount", 32'(nPcL), 32'(expPcL));
        checkOutput("pcIncCount", 32'(nPcI), 32'(expPcI));
        checkOutput("pcExclusive", 32'(nBoth), 32'd0);
        checkOutput("overflowFlag", 32'(overflowFlag), 32'(ovfModel));
        checkOutput("haltedState", 32'(halted), 32'(isHalt));
    endtask

    initial begin
        logic [15:0] instr;
        for (int i = 0; i < 16; i++) branchMap[i] = FUNC_SET;
        branchMap[0] = FUNC_LSS;
        branchMap[1] = FUNC_EQL;
        branchMap[2] = FUNC_GRT;
        _resetN = 1'b0; _start = 1'b0; _instr = 16'h0; _instrValid = 1'b0;
        _memReady = 1'b0; _compareBit = 1'b0; _overflow = 1'b0;

        doReset();
        startUnit();
        applyStimulus(16'h0452, 1'b0, 1'b0, 0);
        applyStimulus(16'h4392, 1'b0, 1'b0, 3);
        applyStimulus(16'hC4A4, 1'b1, 1'b0, 0);
        applyStimulus(16'hC4A4, 1'b0, 1'b0, 0);
        applyStimulus(16'hCC12, 1'b1, 1'b0, 0);
        applyStimulus(16'h8A36, 1'b0, 1'b0, 1);

        for (int n = 0; n < 30; n++) begin
            instr = 16'($urandom);
            if (instr[15:10] == 6'h3F) instr[13:10] = 4'h0;
            applyStimulus(instr, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
        end

        applyStimulus(16'h0C52, 1'b0, 1'b1, 0);
        applyStimulus(16'h0852, 1'b0, 1'b0, 0);
        checkOutput("stickyOverflow", 32'(overflowFlag), 32'd1);

        applyStimulus(16'hFC00, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            _start = 1'(i % 2);
            _instrValid = 1'b1;
            _memReady = 1'b1;
            @(negedge _clock);
            checkOutput("haltQuiet", 32'({halted, instrReq, regWrite, memRead, memWrite, pcIncrement, pcLoad}), 32'h40);
        end
        _start = 1'b0; _instrValid = 1'b0; _memReady = 1'b0;

        doReset();
        startUnit();
        applyStimulus(16'h0452, 1'b0, 1'b1, 0);
        _instr = 16'h80A2; _instrValid = 1'b1; _compareBit = 1'b0; _overflow = 1'b0; _memReady = 1'b0;
        @(negedge _clock);
        _instrValid = 1'b0;
        repeat (2) @(negedge _clock);
        checkOutput("memWriteActive", 32'(memWrite), 32'd1);
        #2 _resetN = 1'b0;
        #1;
        checkOutput("memWriteAsyncDrop", 32'(memWrite), 32'd0);
        checkOutput("resetMidMemory", 32'({instrReq, overflowFlag, halted, funcCode}), 32'd0);
        @(negedge _clock);
        _resetN = 1'b1;
        ovfModel = 1'b0;
        repeat (2) @(negedge _clock);
        checkOutput("idleAfterReset", 32'(instrReq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
